// File: rtl/aes_decipher_ctrl_pkg.sv
// Shared definitions for the AES inverse-cipher controller: key length codes,
// round counts, FSM encoding and the GF(2^8) column/row helpers.
package aes_decipher_ctrl_pkg;

  localparam logic [1:0] AES_128_BIT_KEY = 2'h0;
  localparam logic [1:0] AES_192_BIT_KEY = 2'h1;
  localparam logic [1:0] AES_256_BIT_KEY = 2'h2;

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES192_ROUNDS = 4'hc;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_INIT  = 3'd1,
    CTRL_SHIFT = 3'd2,
    CTRL_SBOX  = 3'd3,
    CTRL_MAIN  = 3'd4,
    CTRL_FINAL = 3'd5
  } ctrl_state_t;

  // The unused code 2'h3 falls back to the 128-bit round count.
  function automatic logic [3:0] num_rounds(input logic [1:0] keylen);
    case (keylen)
      AES_192_BIT_KEY: return AES192_ROUNDS;
      AES_256_BIT_KEY: return AES256_ROUNDS;
      default:         return AES128_ROUNDS;
    endcase
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm2(gm2(gm2(b)) ^ b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm2(gm2(gm2(b) ^ b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm2(gm2(gm2(b) ^ b) ^ b);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3),
            gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3)};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
    return {inv_mixw(s[127:96]), inv_mixw(s[95:64]),
            inv_mixw(s[63:32]),  inv_mixw(s[31:0])};
  endfunction

  // Row r of column c comes from column (c - r) mod 4.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

endpackage

// File: rtl/aes_decipher_ctrl_if.sv
// Handshake and data bus between the core FSM / key memory and the
// inverse-cipher controller.
interface aes_decipher_ctrl_if;

  logic         next;
  logic [1:0]   keylen;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, block, round_key,
    input  round_key_addr, new_block, ready
  );

  modport slave (
    input  next, keylen, block, round_key,
    output round_key_addr, new_block, ready
  );

endinterface

// File: rtl/aes_decipher_ctrl_inv_sbox.sv
// Single-byte AES inverse S-box as a constant lookup table.
module aes_inv_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign result = INV_SBOX[data];

endmodule

// File: rtl/aes_decipher_ctrl.sv
// Sequenced AES inverse cipher for one 128-bit block; InvSubBytes is shared
// across the four state words, one word per cycle.
module aes_decipher_ctrl
  import aes_decipher_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  aes_decipher_ctrl_if.slave bus
);

  ctrl_state_t       state_q, state_d;
  logic [0:3][31:0]  block_q, block_d;
  logic [3:0]        round_ctr_q, round_ctr_d;
  logic [1:0]        sword_ctr_q, sword_ctr_d;
  logic [3:0]        round_ctr_dec;
  logic [3:0]        word_en;
  logic [31:0]       sbox_word;
  logic [31:0]       sub_word;

  assign sbox_word = block_q[sword_ctr_q];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    aes_inv_sbox u_lane (
      .data   (sbox_word[8*i +: 8]),
      .result (sub_word[8*i +: 8])
    );
  end

  always_comb begin
    word_en              = 4'b0000;
    word_en[sword_ctr_q] = (state_q == CTRL_SBOX);
  end

  assign round_ctr_dec = (round_ctr_q != 4'd0) ? round_ctr_q - 4'd1 : round_ctr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CTRL_IDLE;
      block_q     <= '0;
      round_ctr_q <= 4'd0;
      sword_ctr_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    case (state_q)
      CTRL_IDLE: begin
        if (bus.next) begin
          block_d     = bus.block;
          round_ctr_d = num_rounds(bus.keylen);
          state_d     = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        block_d     = block_q ^ bus.round_key;
        round_ctr_d = round_ctr_dec;
        state_d     = CTRL_SHIFT;
      end
      CTRL_SHIFT: begin
        block_d     = inv_shiftrows(block_q);
        sword_ctr_d = 2'd0;
        state_d     = CTRL_SBOX;
      end
      CTRL_SBOX: begin
        for (int i = 0; i < 4; i++) begin
          if (word_en[i]) block_d[i] = sub_word;
        end
        sword_ctr_d = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) begin
          state_d = (round_ctr_q == 4'd0) ? CTRL_FINAL : CTRL_MAIN;
        end
      end
      CTRL_MAIN: begin
        block_d     = inv_mixcolumns(block_q ^ bus.round_key);
        round_ctr_d = round_ctr_dec;
        state_d     = CTRL_SHIFT;
      end
      CTRL_FINAL: begin
        block_d = block_q ^ bus.round_key;
        state_d = CTRL_IDLE;
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  // round_ctr is already 0 in IDLE and FINAL, so it doubles as a glitch-free key address.
  assign bus.round_key_addr = round_ctr_q;
  assign bus.new_block      = block_q;
  assign bus.ready          = (state_q == CTRL_IDLE);

endmodule
